// File: rtl/frag_attr_seq.sv
// frag_attr_seq: fragment attribute sequencer.
// Latches one fragment, then drives a shared interpolator with one depth job
// followed by one job per attribute, and collects every result into a single
// output beat. All data is opaque recFN and passes through untouched.
// Optional build macro: ATTR_SEQ_FLAT_BYPASS_EN -- when defined, flat
// attributes are resolved locally (provoking vertex value) without issuing an
// interpolator job.
module frag_attr_seq #(
  parameter int N_ATTR = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frag_valid,
  output logic                  frag_ready,
  input  logic [65:0]           frag_P,
  input  logic [65:0]           frag_Pa,
  input  logic [65:0]           frag_Pb,
  input  logic [65:0]           frag_Pc,
  input  logic [32:0]           frag_za,
  input  logic [32:0]           frag_zb,
  input  logic [32:0]           frag_zc,
  input  logic [33*N_ATTR-1:0]  frag_fa,
  input  logic [33*N_ATTR-1:0]  frag_fb,
  input  logic [33*N_ATTR-1:0]  frag_fc,
  input  logic [4*N_ATTR-1:0]   frag_flags,
  output logic                  ip_in_valid,
  input  logic                  ip_in_ready,
  input  logic                  ip_out_valid,
  output logic [65:0]           ip_P,
  output logic [65:0]           ip_Pa,
  output logic [65:0]           ip_Pb,
  output logic [65:0]           ip_Pc,
  output logic [32:0]           ip_za,
  output logic [32:0]           ip_zb,
  output logic [32:0]           ip_zc,
  output logic [32:0]           ip_fa,
  output logic [32:0]           ip_fb,
  output logic [32:0]           ip_fc,
  output logic [3:0]            ip_flags,
  input  logic [32:0]           ip_f,
  input  logic [32:0]           ip_z,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32:0]           out_z,
  output logic [33*N_ATTR-1:0]  out_f,
  output logic                  busy
);

  localparam int IW = (N_ATTR > 1) ? $clog2(N_ATTR) : 1;
  localparam logic [2:0] LAST = 3'(N_ATTR - 1);

  typedef enum logic [2:0] {
    IDLE, DEPTH_ISSUE, DEPTH_WAIT, ATTR_ISSUE, ATTR_WAIT, DONE
  } state_t;

  state_t                  state, state_nxt;
  logic [2:0]              idx, idx_nxt;
  logic [IW-1:0]           sel;

  logic [65:0]             p_q, pa_q, pb_q, pc_q;
  logic [32:0]             za_q, zb_q, zc_q, z_q;
  logic [N_ATTR-1:0][32:0] fa_q, fb_q, fc_q, f_q;
  logic [N_ATTR-1:0][2:0]  fl_q;
  logic [2:0]              cur_fl;

  logic                    accept, cap_z, cap_f, bypass;
  logic [32:0]             cap_val;
  logic                    unused_flag_msb;

  assign sel    = idx[IW-1:0];
  assign cur_fl = fl_q[sel];
  assign accept = frag_valid & frag_ready;

  assign frag_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign out_valid  = (state == DONE);

  assign ip_P  = p_q;
  assign ip_Pa = pa_q;
  assign ip_Pb = pb_q;
  assign ip_Pc = pc_q;
  assign ip_za = za_q;
  assign ip_zb = zb_q;
  assign ip_zc = zc_q;
  assign ip_fa = fa_q[sel];
  assign ip_fb = fb_q[sel];
  assign ip_fc = fc_q[sel];
  assign out_z = z_q;
  assign out_f = f_q;

  // Bit 3 of each attribute's flag nibble carries no meaning here.
  always_comb begin
    unused_flag_msb = 1'b0;
    for (int i = 0; i < N_ATTR; i++) unused_flag_msb ^= frag_flags[4*i+3];
  end

  // State and attribute index register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state, issue handshake and result-capture strobes.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    ip_in_valid = 1'b0;
    ip_flags    = 4'b0000;
    cap_z       = 1'b0;
    cap_f       = 1'b0;
    cap_val     = ip_f;
    bypass      = 1'b0;
    case (state)
      IDLE: begin
        if (frag_valid) begin
          state_nxt = DEPTH_ISSUE;
          idx_nxt   = '0;
        end
      end
      DEPTH_ISSUE: begin
        ip_in_valid = 1'b1;
        ip_flags    = 4'b1000;
        if (ip_in_ready) state_nxt = DEPTH_WAIT;
      end
      DEPTH_WAIT: begin
        if (ip_out_valid) begin
          cap_z     = 1'b1;
          state_nxt = ATTR_ISSUE;
        end
      end
      ATTR_ISSUE: begin
        ip_flags = {1'b0, cur_fl};
`ifdef ATTR_SEQ_FLAT_BYPASS_EN
        bypass = cur_fl[1];
`endif
        if (bypass) begin
          // Flat shading: take the provoking vertex value directly.
          cap_f   = 1'b1;
          cap_val = cur_fl[0] ? fc_q[sel] : fa_q[sel];
        end else begin
          ip_in_valid = 1'b1;
          if (ip_in_ready) state_nxt = ATTR_WAIT;
        end
      end
      ATTR_WAIT: begin
        if (ip_out_valid) cap_f = 1'b1;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A captured attribute either finishes the fragment or moves to the next.
    if (cap_f) begin
      if (idx == LAST) begin
        state_nxt = DONE;
      end else begin
        idx_nxt   = idx + 3'd1;
        state_nxt = ATTR_ISSUE;
      end
    end
  end

  // Fragment latch on acceptance and result collection.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_q  <= '0;
      pa_q <= '0;
      pb_q <= '0;
      pc_q <= '0;
      za_q <= '0;
      zb_q <= '0;
      zc_q <= '0;
      fa_q <= '0;
      fb_q <= '0;
      fc_q <= '0;
      fl_q <= '0;
      z_q  <= '0;
      f_q  <= '0;
    end else begin
      if (accept) begin
        p_q  <= frag_P;
        pa_q <= frag_Pa;
        pb_q <= frag_Pb;
        pc_q <= frag_Pc;
        za_q <= frag_za;
        zb_q <= frag_zb;
        zc_q <= frag_zc;
        fa_q <= frag_fa;
        fb_q <= frag_fb;
        fc_q <= frag_fc;
        for (int i = 0; i < N_ATTR; i++) fl_q[i] <= frag_flags[4*i +: 3];
      end
      if (cap_z) z_q <= ip_z;
      if (cap_f) f_q[sel] <= cap_val;
    end
  end

endmodule

// File: tb/tb_frag_attr_seq.sv
// tb_frag_attr_seq: directed bench for frag_attr_seq with a fixed-latency
// interpolator model (5 cycles from issue handshake to sampled result).
module tb_frag_attr_seq;
  localparam int NA = 4;
  localparam logic [32:0] R_HALF = 33'h0_7F80_0000;
  localparam logic [32:0] R1     = 33'h0_8000_0000;
  localparam logic [32:0] R2     = 33'h0_8080_0000;
  localparam logic [32:0] R3     = 33'h0_80C0_0000;
  localparam logic [32:0] R4     = 33'h0_8100_0000;
  localparam logic [32:0] R7     = 33'h0_8160_0000;
  localparam logic [32:0] JUNK   = 33'h1_5A5A_5A5A;
  localparam logic [65:0] P_A    = 66'h1_2345_6789_ABCD_EF01;
  localparam logic [65:0] P_B    = 66'h2_FEDC_BA98_7654_3210;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic frag_valid = 1'b0, frag_ready;
  logic [65:0] frag_P = '0, frag_Pa = '0, frag_Pb = '0, frag_Pc = '0;
  logic [32:0] frag_za = '0, frag_zb = '0, frag_zc = '0;
  logic [33*NA-1:0] frag_fa = '0, frag_fb = '0, frag_fc = '0;
  logic [4*NA-1:0] frag_flags = '0;
  logic ip_in_valid, ip_in_ready = 1'b1, ip_out_valid;
  logic [65:0] ip_P, ip_Pa, ip_Pb, ip_Pc;
  logic [32:0] ip_za, ip_zb, ip_zc, ip_fa, ip_fb, ip_fc;
  logic [3:0] ip_flags;
  logic [32:0] ip_f, ip_z;
  logic out_valid, out_ready = 1'b1;
  logic [32:0] out_z;
  logic [33*NA-1:0] out_f;
  logic busy;

  int n_chk = 0;
  int n_fail = 0;

  frag_attr_seq #(.N_ATTR(NA)) dut (
    .clk(clk), .reset(reset),
    .frag_valid(frag_valid), .frag_ready(frag_ready),
    .frag_P(frag_P), .frag_Pa(frag_Pa), .frag_Pb(frag_Pb), .frag_Pc(frag_Pc),
    .frag_za(frag_za), .frag_zb(frag_zb), .frag_zc(frag_zc),
    .frag_fa(frag_fa), .frag_fb(frag_fb), .frag_fc(frag_fc),
    .frag_flags(frag_flags),
    .ip_in_valid(ip_in_valid), .ip_in_ready(ip_in_ready), .ip_out_valid(ip_out_valid),
    .ip_P(ip_P), .ip_Pa(ip_Pa), .ip_Pb(ip_Pb), .ip_Pc(ip_Pc),
    .ip_za(ip_za), .ip_zb(ip_zb), .ip_zc(ip_zc),
    .ip_fa(ip_fa), .ip_fb(ip_fb), .ip_fc(ip_fc), .ip_flags(ip_flags),
    .ip_f(ip_f), .ip_z(ip_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_f(out_f),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] rec_int(input int k);
    case (k)
      1: rec_int = R1;
      2: rec_int = R2;
      3: rec_int = R3;
      4: rec_int = R4;
      default: rec_int = JUNK;
    endcase
  endfunction

  function automatic logic [32:0] attr_a(input int i);
    attr_a = 33'h0_A000_0000 + 33'(i);
  endfunction

  // Interpolator model: depth job returns 0.5, attribute job k returns k+1.
  logic [2:0]  m_cnt = '0;
  logic        m_ov = 1'b0;
  logic [32:0] m_val = '0;
  int          m_attr = 0;
  int          issue_total = 0;
  logic        stray = 1'b0;
  logic [3:0]  job_flags [16];
  logic [32:0] job_fa [16];

  always @(posedge clk) begin
    if (reset) begin
      m_cnt  <= '0;
      m_ov   <= 1'b0;
      m_attr <= 0;
    end else begin
      m_ov <= 1'b0;
      if (ip_in_valid && ip_in_ready) begin
        m_cnt <= 3'd4;
        issue_total <= issue_total + 1;
        job_flags[issue_total % 16] <= ip_flags;
        job_fa[issue_total % 16]    <= ip_fa;
        if (ip_flags[3]) begin
          m_val  <= R_HALF;
          m_attr <= 0;
        end else begin
          m_val  <= rec_int(m_attr + 1);
          m_attr <= m_attr + 1;
        end
      end else if (m_cnt == 3'd1) begin
        m_ov  <= 1'b1;
        m_cnt <= '0;
      end else if (m_cnt != 3'd0) begin
        m_cnt <= m_cnt - 3'd1;
      end
    end
  end

  assign ip_out_valid = m_ov | stray;
  assign ip_z = m_ov ? m_val : JUNK;
  assign ip_f = m_ov ? m_val : JUNK;

  task automatic load_frag(input logic [65:0] p, input logic [4*NA-1:0] fl);
    frag_P  = p;
    frag_Pa = p ^ 66'h1;
    frag_Pb = p ^ 66'h2;
    frag_Pc = p ^ 66'h3;
    frag_za = 33'h0_1111_1111;
    frag_zb = 33'h0_2222_2222;
    frag_zc = 33'h0_3333_3333;
    for (int i = 0; i < NA; i++) begin
      frag_fa[33*i +: 33] = attr_a(i);
      frag_fb[33*i +: 33] = 33'h0_B000_0000 + 33'(i);
      frag_fc[33*i +: 33] = 33'h0_C000_0000 + 33'(i);
    end
    frag_flags = fl;
  endtask

  // Present a fragment for one cycle; returns at the negedge of cycle T+1.
  task automatic send_frag();
    frag_valid = 1'b1;
    @(negedge clk);
    frag_valid = 1'b0;
  endtask

  task automatic wait_out(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      if (out_valid) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (frag_ready !== 1'b1) begin n_fail++; $display("FAIL rst_frag_ready got=%b exp=1", frag_ready); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
    n_chk++; if (ip_in_valid !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valids got=%b%b exp=00", ip_in_valid, out_valid); end
    n_chk++; if (out_z !== '0 || out_f !== '0 || ip_P !== '0 || ip_fa !== '0 || ip_flags !== '0) begin
      n_fail++; $display("FAIL rst_data got out_z=%h out_f=%h ip_P=%h ip_fa=%h ip_flags=%h exp=0", out_z, out_f, ip_P, ip_fa, ip_flags); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int base;
    bit ok;
    load_frag(P_A, '0);
    ip_in_ready = 1'b1;
    out_ready   = 1'b1;
    base = issue_total;
    send_frag();
    n_chk++; if (busy !== 1'b1 || frag_ready !== 1'b0) begin n_fail++; $display("FAIL basic_busy got busy=%b ready=%b exp=1/0", busy, frag_ready); end
    n_chk++; if (ip_in_valid !== 1'b1) begin n_fail++; $display("FAIL basic_first_issue got=%b exp=1", ip_in_valid); end
    n_chk++; if (ip_flags !== 4'b1000) begin n_fail++; $display("FAIL basic_depth_flags got=%b exp=1000", ip_flags); end
    n_chk++; if (ip_fa !== attr_a(0) || ip_P !== P_A || ip_Pc !== (P_A ^ 66'h3) || ip_zc !== 33'h0_3333_3333) begin
      n_fail++; $display("FAIL basic_latch got fa=%h P=%h Pc=%h zc=%h", ip_fa, ip_P, ip_Pc, ip_zc); end
    @(negedge clk);
    n_chk++; if (ip_in_valid !== 1'b0) begin n_fail++; $display("FAIL basic_issue_drop got=%b exp=0", ip_in_valid); end
    wait_out(200, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL basic_timeout got out_valid=0 exp=1"); end
    n_chk++; if (out_z !== R_HALF) begin n_fail++; $display("FAIL basic_out_z got=%h exp=%h", out_z, R_HALF); end
    n_chk++; if (out_f !== {R4, R3, R2, R1}) begin n_fail++; $display("FAIL basic_out_f got=%h exp=%h", out_f, {R4, R3, R2, R1}); end
    n_chk++; if (issue_total - base !== 5) begin n_fail++; $display("FAIL basic_jobs got=%0d exp=5", issue_total - base); end
    n_chk++; if (job_flags[base % 16] !== 4'b1000 || job_flags[(base + 4) % 16] !== 4'b0000) begin
      n_fail++; $display("FAIL basic_job_flags got=%b/%b exp=1000/0000", job_flags[base % 16], job_flags[(base + 4) % 16]); end
    n_chk++; if (job_fa[(base + 3) % 16] !== attr_a(2)) begin n_fail++; $display("FAIL basic_job_fa got=%h exp=%h", job_fa[(base + 3) % 16], attr_a(2)); end
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0 || frag_ready !== 1'b1) begin n_fail++; $display("FAIL basic_return got valid=%b ready=%b exp=0/1", out_valid, frag_ready); end
  endtask

  task automatic test_flag_routing();
    int base;
    bit ok;
    load_frag(P_B, 16'h00D0);
    base = issue_total;
    send_frag();
    wait_out(200, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL flags_timeout got out_valid=0 exp=1"); end
    n_chk++; if (job_flags[(base + 2) % 16] !== 4'b0101) begin n_fail++; $display("FAIL flags_attr1 got=%b exp=0101", job_flags[(base + 2) % 16]); end
    n_chk++; if (job_fa[(base + 2) % 16] !== attr_a(1)) begin n_fail++; $display("FAIL flags_attr1_fa got=%h exp=%h", job_fa[(base + 2) % 16], attr_a(1)); end
    n_chk++; if (job_flags[(base + 1) % 16] !== 4'b0000) begin n_fail++; $display("FAIL flags_attr0 got=%b exp=0000", job_flags[(base + 1) % 16]); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int base;
    bit ok;
    load_frag(P_A, 16'h0400);
    ip_in_ready = 1'b0;
    base = issue_total;
    send_frag();
    for (int j = 0; j < 5; j++) begin
      ok = 1'b0;
      for (int c = 0; c < 100 && !ok; c++) begin
        if (ip_in_valid) ok = 1'b1;
        else @(negedge clk);
      end
      n_chk++; if (!ok) begin n_fail++; $display("FAIL bp_issue_wait job=%0d got ip_in_valid=0 exp=1", j); end
      if (j == 3) begin
        for (int c = 0; c < 7; c++) begin
          stray = (c == 2 || c == 4);
          n_chk++; if (ip_in_valid !== 1'b1 || ip_flags !== 4'b0100 || ip_fa !== attr_a(2)) begin
            n_fail++; $display("FAIL bp_hold cyc=%0d got v=%b fl=%b fa=%h exp 1/0100/%h", c, ip_in_valid, ip_flags, ip_fa, attr_a(2)); end
          @(negedge clk);
        end
        stray = 1'b0;
      end
      ip_in_ready = 1'b1;
      @(negedge clk);
      ip_in_ready = 1'b0;
      n_chk++; if (ip_in_valid !== 1'b0) begin n_fail++; $display("FAIL bp_accept_drop job=%0d got=%b exp=0", j, ip_in_valid); end
    end
    wait_out(100, ok);
    ip_in_ready = 1'b1;
    n_chk++; if (!ok) begin n_fail++; $display("FAIL bp_timeout got out_valid=0 exp=1"); end
    n_chk++; if (out_f !== {R4, R3, R2, R1} || out_z !== R_HALF) begin n_fail++; $display("FAIL bp_result got z=%h f=%h exp z=%h f=%h", out_z, out_f, R_HALF, {R4, R3, R2, R1}); end
    n_chk++; if (issue_total - base !== 5) begin n_fail++; $display("FAIL bp_jobs got=%0d exp=5", issue_total - base); end
    @(negedge clk);
  endtask

  task automatic test_out_stall();
    bit ok;
    load_frag(P_A, '0);
    out_ready = 1'b0;
    send_frag();
    wait_out(200, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL stall_timeout got out_valid=0 exp=1"); end
    load_frag(P_B, '0);
    frag_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_chk++; if (out_valid !== 1'b1 || frag_ready !== 1'b0 || out_z !== R_HALF || out_f !== {R4, R3, R2, R1}) begin
        n_fail++; $display("FAIL stall_hold cyc=%0d got v=%b rdy=%b z=%h f=%h", c, out_valid, frag_ready, out_z, out_f); end
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (frag_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release got rdy=%b v=%b exp=1/0", frag_ready, out_valid); end
    n_chk++; if (ip_P !== P_A) begin n_fail++; $display("FAIL stall_no_store got=%h exp=%h", ip_P, P_A); end
    @(negedge clk);
    frag_valid = 1'b0;
    n_chk++; if (busy !== 1'b1 || ip_P !== P_B) begin n_fail++; $display("FAIL stall_second_accept got busy=%b P=%h exp=1/%h", busy, ip_P, P_B); end
    wait_out(200, ok);
    n_chk++; if (!ok || out_f !== {R4, R3, R2, R1}) begin n_fail++; $display("FAIL stall_second_result got v=%b f=%h", ok, out_f); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit bad;
    load_frag(P_B, '0);
    send_frag();
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      if (ip_in_valid && !ip_flags[3]) ok = 1'b1;
      else @(negedge clk);
    end
    n_chk++; if (!ok) begin n_fail++; $display("FAIL rmid_reach_attr got=0 exp=1"); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0 || frag_ready !== 1'b1 || busy !== 1'b0 || ip_in_valid !== 1'b0) begin
      n_fail++; $display("FAIL rmid_ctrl got v=%b rdy=%b busy=%b iv=%b exp 0/1/0/0", out_valid, frag_ready, busy, ip_in_valid); end
    n_chk++; if (ip_P !== '0 || out_z !== '0) begin n_fail++; $display("FAIL rmid_data got P=%h z=%h exp=0", ip_P, out_z); end
    @(negedge clk);
    reset = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (out_valid || ip_in_valid || busy) bad = 1'b1;
      @(negedge clk);
    end
    n_chk++; if (bad) begin n_fail++; $display("FAIL rmid_no_beat got activity=1 exp=0"); end
  endtask

  task automatic test_flat();
    int base;
    bit ok;
    logic [32:0] exp_f3;
    int exp_jobs;
    load_frag(P_A, 16'h3000);
    frag_fc[99 +: 33] = R7;
    base = issue_total;
    send_frag();
    wait_out(200, ok);
`ifdef ATTR_SEQ_FLAT_BYPASS_EN
    exp_f3   = R7;
    exp_jobs = 4;
`else
    exp_f3   = R4;
    exp_jobs = 5;
    n_chk++; if (job_flags[(base + 4) % 16] !== 4'b0011) begin n_fail++; $display("FAIL flat_issued_flags got=%b exp=0011", job_flags[(base + 4) % 16]); end
`endif
    n_chk++; if (!ok) begin n_fail++; $display("FAIL flat_timeout got out_valid=0 exp=1"); end
    n_chk++; if (out_f[99 +: 33] !== exp_f3) begin n_fail++; $display("FAIL flat_slot3 got=%h exp=%h", out_f[99 +: 33], exp_f3); end
    n_chk++; if (out_f[98:0] !== {R3, R2, R1}) begin n_fail++; $display("FAIL flat_low_slots got=%h exp=%h", out_f[98:0], {R3, R2, R1}); end
    n_chk++; if (issue_total - base !== exp_jobs) begin n_fail++; $display("FAIL flat_jobs got=%0d exp=%0d", issue_total - base, exp_jobs); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flag_routing();
    test_backpressure();
    test_out_stall();
    test_flat();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
